led_pattern_gen: RTL and testbench

Multi-channel LED pattern generator. It is the parametrised successor of the free-running LED blink counter.
- Drives CHANNELS LED outputs.
- Each channel independently selects OFF, ON, BLINK (square wave with programmable half-period) or BREATHE (triangle-ramped PWM brightness).
- A shared prescaler generates a slow time-base tick. A shared free-running counter provides the PWM carrier.
- Sits between board top-level LED pins and control logic (CSR block or a static tie-off).

---
 rtl/led_pattern_gen.sv | 163 ++++++++++++++++
 tb/tb_led_pattern_gen.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator.
// A shared prescaler makes a slow time-base tick and a shared free-running
// counter is the PWM carrier. Each channel runs OFF / ON / BLINK / BREATHE
// independently.
//
// led_chan ports:
//   clk, rst      clock, synchronous active-high reset
//   tick          time-base tick (combinational from the shared prescaler)
//   mode, rate    this channel's MODE / RATE fields
//   pwm           shared PWM carrier
//   led           registered LED drive, polarity per ACTIVE_LOW
//
// led_pattern_gen ports:
//   CLK, RST      clock, synchronous active-high reset
//   MODE          2 bits per channel: 00 OFF, 01 ON, 10 BLINK, 11 BREATHE
//   RATE          8 bits per channel: ticks per half-period / level step (0 acts as 1)
//   LED           registered LED drive per channel
//   TICK          registered one-cycle pulse per time-base tick

module led_chan #(
  parameter int PWM_W      = 8,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic [1:0]       mode,
  input  logic [7:0]       rate,
  input  logic [PWM_W-1:0] pwm,
  output logic             led
);
  typedef enum logic [1:0] {
    M_OFF     = 2'b00,
    M_ON      = 2'b01,
    M_BLINK   = 2'b10,
    M_BREATHE = 2'b11
  } mode_e;

  localparam logic [PWM_W-1:0] LVL_TOP = {{(PWM_W-1){1'b1}}, 1'b0};
  localparam logic [PWM_W-1:0] LVL_ONE = {{(PWM_W-1){1'b0}}, 1'b1};

  mode_e            mode_q;
  logic [7:0]       cnt, cnt_n, eff_rate;
  logic [8:0]       cnt_inc;
  logic             phase, phase_n;
  logic [PWM_W-1:0] level, level_n;
  logic             dir_dn, dir_dn_n;
  logic             step, lit;

  always_comb begin
    eff_rate = (rate == 8'd0) ? 8'd1 : rate;
    cnt_inc  = {1'b0, cnt} + 9'd1;
    cnt_n    = cnt;
    phase_n  = phase;
    level_n  = level;
    dir_dn_n = dir_dn;
    step     = 1'b0;
    lit      = 1'b0;

    // A mode change restarts the channel and swallows a coincident tick;
    // OFF/ON keep the counters parked at their reset values.
    if (mode_e'(mode) != mode_q || mode_q == M_OFF || mode_q == M_ON) begin
      cnt_n    = '0;
      phase_n  = 1'b0;
      level_n  = '0;
      dir_dn_n = 1'b0;
    end else if (tick) begin
      // >= so a RATE lowered below the running count steps on the next tick
      if (cnt_inc >= {1'b0, eff_rate}) begin
        cnt_n = '0;
        step  = 1'b1;
      end else begin
        cnt_n = cnt_inc[7:0];
      end
    end

    if (step) begin
      if (mode_q == M_BLINK) begin
        phase_n = ~phase;
      end else if (!dir_dn) begin
        level_n = level + 1'b1;
        if (level == LVL_TOP) dir_dn_n = 1'b1;   // turn at max, no repeat
      end else begin
        level_n = level - 1'b1;
        if (level == LVL_ONE) dir_dn_n = 1'b0;   // turn at 0, no repeat
      end
    end

    unique case (mode_q)
      M_OFF:     lit = 1'b0;
      M_ON:      lit = 1'b1;
      M_BLINK:   lit = phase;
      M_BREATHE: lit = (pwm < level);
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= M_OFF;
      cnt    <= '0;
      phase  <= 1'b0;
      level  <= '0;
      dir_dn <= 1'b0;
      led    <= ACTIVE_LOW;
    end else begin
      mode_q <= mode_e'(mode);
      cnt    <= cnt_n;
      phase  <= phase_n;
      level  <= level_n;
      dir_dn <= dir_dn_n;
      led    <= lit ^ ACTIVE_LOW;
    end
  end
endmodule

module led_pattern_gen #(
  parameter int CHANNELS   = 3,
  parameter int PRESCALE   = 48000,
  parameter int PWM_W      = 8,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [2*CHANNELS-1:0] MODE,
  input  logic [8*CHANNELS-1:0] RATE,
  output logic [CHANNELS-1:0]   LED,
  output logic                  TICK
);
  localparam int PRE_W = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;

  logic [PRE_W-1:0] pre;
  logic [PWM_W-1:0] pwm;
  logic             tick_int;

  assign tick_int = (pre == PRE_W'(PRESCALE - 1));

  always_ff @(posedge CLK) begin
    if (RST) begin
      pre  <= '0;
      pwm  <= '0;
      TICK <= 1'b0;
    end else begin
      pre  <= tick_int ? '0 : pre + 1'b1;
      pwm  <= pwm + 1'b1;
      TICK <= tick_int;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    led_chan #(
      .PWM_W      (PWM_W),
      .ACTIVE_LOW (ACTIVE_LOW)
    ) u_ch (
      .clk  (CLK),
      .rst  (RST),
      .tick (tick_int),
      .mode (MODE[2*i +: 2]),
      .rate (RATE[8*i +: 8]),
      .pwm  (pwm),
      .led  (LED[i])
    );
  end
endmodule

// File: tb/tb_led_pattern_gen.sv
// Bench for led_pattern_gen: PRESCALE=4, PWM_W=4, CHANNELS=3, one ACTIVE_LOW=1
// and one ACTIVE_LOW=0 instance on shared inputs. A cycle model pushes the
// expected outputs at every rising edge; a monitor pops and compares them on
// the falling edge. Scenario tasks add their own targeted checks.
module tb_led_pattern_gen;
  localparam int CH  = 3;
  localparam int PRE = 4;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [5:0]  MODE = '0;
  logic [23:0] RATE = '0;
  logic [2:0]  LED, LED_AH;
  logic        TICK, TICK_AH;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  led_pattern_gen #(.CHANNELS(CH), .PRESCALE(PRE), .PWM_W(4), .ACTIVE_LOW(1'b1)) dut (
    .CLK(CLK), .RST(RST), .MODE(MODE), .RATE(RATE), .LED(LED), .TICK(TICK));
  led_pattern_gen #(.CHANNELS(CH), .PRESCALE(PRE), .PWM_W(4), .ACTIVE_LOW(1'b0)) dut_ah (
    .CLK(CLK), .RST(RST), .MODE(MODE), .RATE(RATE), .LED(LED_AH), .TICK(TICK_AH));

  // ---------------- reference model + scoreboard ----------------
  int         m_pre = 0, m_pwm = 0;
  int         m_cnt[CH], m_phase[CH], m_level[CH], m_dir[CH];
  logic [1:0] m_mq[CH];
  logic [2:0] e_led = 3'b111;
  logic       e_tick = 1'b0;
  logic [3:0] sb_q[$];

  always @(posedge CLK) begin : model
    logic       mt, lit;
    logic [1:0] md;
    int         er;
    if (RST) begin
      m_pre = 0; m_pwm = 0; e_tick = 1'b0; e_led = 3'b111;
      for (int i = 0; i < CH; i++) begin
        m_cnt[i] = 0; m_phase[i] = 0; m_level[i] = 0; m_dir[i] = 0; m_mq[i] = 2'b00;
      end
    end else begin
      mt = (m_pre == PRE - 1);
      for (int i = 0; i < CH; i++) begin
        case (m_mq[i])
          2'b01:   lit = 1'b1;
          2'b10:   lit = (m_phase[i] != 0);
          2'b11:   lit = (m_pwm < m_level[i]);
          default: lit = 1'b0;
        endcase
        e_led[i] = ~lit;
        md = MODE[2*i +: 2];
        er = (RATE[8*i +: 8] == 8'd0) ? 1 : int'(RATE[8*i +: 8]);
        if (md != m_mq[i] || m_mq[i] == 2'b00 || m_mq[i] == 2'b01) begin
          m_cnt[i] = 0; m_phase[i] = 0; m_level[i] = 0; m_dir[i] = 0;
        end else if (mt) begin
          if (m_cnt[i] + 1 >= er) begin
            m_cnt[i] = 0;
            if (m_mq[i] == 2'b10) m_phase[i] = 1 - m_phase[i];
            else if (m_dir[i] == 0) begin
              m_level[i]++;
              if (m_level[i] == 15) m_dir[i] = 1;
            end else begin
              m_level[i]--;
              if (m_level[i] == 0) m_dir[i] = 0;
            end
          end else begin
            m_cnt[i]++;
          end
        end
        m_mq[i] = md;
      end
      m_pre  = mt ? 0 : m_pre + 1;
      m_pwm  = (m_pwm + 1) % 16;
      e_tick = mt;
    end
    sb_q.push_back({e_led, e_tick});
  end

  always @(negedge CLK) begin : monitor
    logic [3:0] e;
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      checks += 3;
      if (LED !== e[3:1]) begin
        errors++; $display("FAIL sb_led t=%0t: got %b want %b", $time, LED, e[3:1]);
      end
      if (TICK !== e[0]) begin
        errors++; $display("FAIL sb_tick t=%0t: got %b want %b", $time, TICK, e[0]);
      end
      if (LED_AH !== ~e[3:1]) begin
        errors++; $display("FAIL sb_led_ah t=%0t: got %b want %b", $time, LED_AH, ~e[3:1]);
      end
    end
  end

  // ---------------- helpers ----------------
  function automatic int tri_lvl(input int n);
    int m;
    m = n % 30;
    return (m <= 15) ? m : 30 - m;
  endfunction

  // One reset cycle; returns at the start of cycle 0 (first cycle with RST low).
  task automatic do_reset(input logic [5:0] md, input logic [23:0] rt);
    @(negedge CLK); RST = 1'b1; MODE = md; RATE = rt;
    @(negedge CLK); RST = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    RST = 1'b1; MODE = '0; RATE = '0;
    repeat (3) @(negedge CLK);
    checks += 2;
    if (LED !== 3'b111) begin errors++; $display("FAIL reset_led: got %b want 111", LED); end
    if (TICK !== 1'b0)  begin errors++; $display("FAIL reset_tick: got %b want 0", TICK); end
    RST = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge CLK);
      checks += 2;
      if (TICK !== (k % 4 == 0)) begin
        errors++; $display("FAIL idle_tick cycle %0d: got %b want %b", k, TICK, (k % 4 == 0));
      end
      if (LED !== 3'b111) begin errors++; $display("FAIL idle_led cycle %0d: got %b want 111", k, LED); end
    end
  endtask

  task automatic test_on_off();
    logic [2:0] exp;
    do_reset(6'b00_00_01, '0);
    for (int k = 1; k <= 6; k++) begin
      @(negedge CLK);
      exp = (k >= 2) ? 3'b110 : 3'b111;
      checks += 2;
      if (LED !== exp) begin errors++; $display("FAIL on_off cycle %0d: got %b want %b", k, LED, exp); end
      if (LED_AH !== ~exp) begin
        errors++; $display("FAIL on_off_ah cycle %0d: got %b want %b", k, LED_AH, ~exp);
      end
    end
  endtask

  task automatic test_blink();
    logic exp;
    do_reset(6'b10_00_00, {8'd2, 16'd0});
    for (int k = 1; k <= 40; k++) begin
      @(negedge CLK);
      exp = (((k - 1) / 8) % 2 == 0);
      checks++;
      if (LED[2] !== exp) begin errors++; $display("FAIL blink_r2 cycle %0d: got %b want %b", k, LED[2], exp); end
    end
    do_reset(6'b10_00_00, 24'd0);
    for (int k = 1; k <= 24; k++) begin
      @(negedge CLK);
      exp = (((k - 1) / 4) % 2 == 0);
      checks++;
      if (LED[2] !== exp) begin errors++; $display("FAIL blink_r0 cycle %0d: got %b want %b", k, LED[2], exp); end
    end
  endtask

  task automatic test_breathe();
    logic exp;
    int   lows;
    do_reset(6'b00_00_11, 24'd1);
    for (int k = 1; k <= 132; k++) begin
      @(negedge CLK);
      exp = !(((k - 1) % 16) < tri_lvl((k - 1) / 4));
      checks += 2;
      if (int'(dut.g_ch[0].u_ch.level) != tri_lvl(k / 4)) begin
        errors++; $display("FAIL breathe_level cycle %0d: got %0d want %0d", k, dut.g_ch[0].u_ch.level, tri_lvl(k / 4));
      end
      if (LED[0] !== exp) begin errors++; $display("FAIL breathe_led cycle %0d: got %b want %b", k, LED[0], exp); end
    end
    // RATE=4 holds level 5 over cycles 80..95, one full carrier window
    do_reset(6'b00_00_11, 24'd4);
    repeat (80) @(negedge CLK);
    lows = 0;
    for (int k = 81; k <= 96; k++) begin
      @(negedge CLK);
      if (LED[0] == 1'b0) lows++;
    end
    checks++;
    if (lows != 5) begin errors++; $display("FAIL breathe_duty5: got %0d lows want 5", lows); end
  endtask

  task automatic test_collision();
    do_reset(6'b00_00_10, 24'd2);
    repeat (11) @(negedge CLK);            // cycle 11 carries a tick
    checks += 2;
    if (dut.g_ch[0].u_ch.phase !== 1'b1) begin
      errors++; $display("FAIL coll_pre_phase: got %b want 1", dut.g_ch[0].u_ch.phase);
    end
    if (dut.g_ch[0].u_ch.cnt !== 8'd0) begin
      errors++; $display("FAIL coll_pre_cnt: got %0d want 0", dut.g_ch[0].u_ch.cnt);
    end
    MODE = 6'b00_00_11;
    @(negedge CLK);
    checks += 3;
    if (dut.g_ch[0].u_ch.cnt !== 8'd0) begin
      errors++; $display("FAIL coll_cnt: got %0d want 0", dut.g_ch[0].u_ch.cnt);
    end
    if (dut.g_ch[0].u_ch.phase !== 1'b0) begin
      errors++; $display("FAIL coll_phase: got %b want 0", dut.g_ch[0].u_ch.phase);
    end
    if (dut.g_ch[0].u_ch.level !== 4'd0) begin
      errors++; $display("FAIL coll_level: got %0d want 0", dut.g_ch[0].u_ch.level);
    end
    repeat (7) @(negedge CLK);             // cycle 19
    checks++;
    if (dut.g_ch[0].u_ch.level !== 4'd0) begin
      errors++; $display("FAIL coll_lvl19: got %0d want 0", dut.g_ch[0].u_ch.level);
    end
    @(negedge CLK);                        // cycle 20
    checks++;
    if (dut.g_ch[0].u_ch.level !== 4'd1) begin
      errors++; $display("FAIL coll_lvl20: got %0d want 1", dut.g_ch[0].u_ch.level);
    end

    do_reset(6'b00_10_00, {8'd0, 8'd10, 8'd0});
    repeat (24) @(negedge CLK);
    checks++;
    if (dut.g_ch[1].u_ch.cnt !== 8'd6) begin
      errors++; $display("FAIL rate_cnt6: got %0d want 6", dut.g_ch[1].u_ch.cnt);
    end
    RATE = {8'd0, 8'd2, 8'd0};
    repeat (3) @(negedge CLK);             // cycle 27, tick pending
    checks++;
    if (dut.g_ch[1].u_ch.phase !== 1'b0) begin
      errors++; $display("FAIL rate_phase27: got %b want 0", dut.g_ch[1].u_ch.phase);
    end
    @(negedge CLK);                        // cycle 28
    checks += 2;
    if (dut.g_ch[1].u_ch.phase !== 1'b1) begin
      errors++; $display("FAIL rate_phase28: got %b want 1", dut.g_ch[1].u_ch.phase);
    end
    if (dut.g_ch[1].u_ch.cnt !== 8'd0) begin
      errors++; $display("FAIL rate_cnt28: got %0d want 0", dut.g_ch[1].u_ch.cnt);
    end
  endtask

  task automatic test_midrun_reset();
    do_reset(6'b00_11_00, {8'd0, 8'd1, 8'd0});
    repeat (37) @(negedge CLK);
    checks++;
    if (dut.g_ch[1].u_ch.level !== 4'd9) begin
      errors++; $display("FAIL mid_level9: got %0d want 9", dut.g_ch[1].u_ch.level);
    end
    RST = 1'b1; MODE = '0; RATE = '0;
    @(negedge CLK);
    checks += 3;
    if (LED !== 3'b111) begin errors++; $display("FAIL mid_led: got %b want 111", LED); end
    if (TICK !== 1'b0) begin errors++; $display("FAIL mid_tick: got %b want 0", TICK); end
    if (dut.g_ch[1].u_ch.level !== 4'd0) begin
      errors++; $display("FAIL mid_level0: got %0d want 0", dut.g_ch[1].u_ch.level);
    end
    RST = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge CLK);
      checks += 2;
      if (TICK !== (k % 4 == 0)) begin
        errors++; $display("FAIL mid_tick cycle %0d: got %b want %b", k, TICK, (k % 4 == 0));
      end
      if (LED !== 3'b111) begin errors++; $display("FAIL mid_idle_led cycle %0d: got %b want 111", k, LED); end
    end
  endtask

  // Random MODE/RATE/RST activity; the scoreboard does the checking.
  task automatic test_random();
    int c;
    do_reset('0, '0);
    for (int n = 0; n < 400; n++) begin
      @(negedge CLK);
      RST = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 11) == 0) begin
        c = $urandom_range(0, CH - 1);
        MODE[2*c +: 2] = 2'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 7) == 0) begin
        c = $urandom_range(0, CH - 1);
        RATE[8*c +: 8] = 8'($urandom_range(0, 3));
      end
    end
    RST = 1'b0;
  endtask

  initial begin
    test_reset();
    test_on_off();
    test_blink();
    test_breathe();
    test_collision();
    test_midrun_reset();
    test_random();
    repeat (2) @(negedge CLK);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
